// File: rtl/frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// frame_buffer_writer
//   Producer-side write controller for a pair of ping-pong frame buffers.
//   Accepts an RGB pixel stream (valid/ready), packs each pixel into a 32-bit
//   word and writes it into buffer 0 or buffer 1, alternating per frame.
//   Stalls the source while the next buffer is still held by the display.
//
//   Optional build macro: FRAME_BUFFER_WRITER_STATS_EN adds the
//   FramesWritten / SOFDrops statistics counters and ports.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   Enable                start filling (sampled in IDLE only)
//   PxR/PxG/PxB           pixel colour components
//   PxSOF, PxValid        start-of-frame marker, pixel valid
//   PxReady               pixel accepted this cycle (decoded from state)
//   Buf0Empty/Buf1Empty   drain pulses from the display controller
//   WData                 write word {8'h00, R, G, B}
//   WE0/WE1, Addr0/Addr1  per-buffer write strobe and address
//   Buf0Full/Buf1Full     buffer holds a complete frame
//   FramesWritten         (stats) completed buffers, saturating
//   SOFDrops              (stats) partial frames discarded by SOF, saturating
// ---------------------------------------------------------------------------
module frame_buffer_writer #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned BUF_DEPTH = 307200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic [7:0]        PxR,
  input  logic [7:0]        PxG,
  input  logic [7:0]        PxB,
  input  logic              PxSOF,
  input  logic              PxValid,
  output logic              PxReady,
  input  logic              Buf0Empty,
  input  logic              Buf1Empty,
  output logic [31:0]       WData,
  output logic              WE0,
  output logic              WE1,
  output logic [ADDR_W-1:0] Addr0,
  output logic [ADDR_W-1:0] Addr1,
  output logic              Buf0Full,
  output logic              Buf1Full
`ifdef FRAME_BUFFER_WRITER_STATS_EN
  ,
  output logic [15:0]       FramesWritten,
  output logic [7:0]        SOFDrops
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL0 = 3'd1;
  localparam logic [2:0] S_FILL1 = 3'd2;
  localparam logic [2:0] S_WAIT0 = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(BUF_DEPTH - 1);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] addr0_nxt, addr1_nxt;
  logic [31:0]       wdata_nxt;
  logic              we0_nxt, we1_nxt;
  logic              full0_nxt, full1_nxt;
  logic              full0_eff, full1_eff;
  logic              accept, in_fill0, in_fill1;
  logic              sof_restart, last_word;

  // Ready is a pure decode of the registered state.
  assign in_fill0 = (state == S_FILL0);
  assign in_fill1 = (state == S_FILL1);
  assign PxReady  = in_fill0 | in_fill1;

  // Next-state and datapath decode.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    addr0_nxt = Addr0;
    addr1_nxt = Addr1;
    wdata_nxt = WData;
    we0_nxt   = 1'b0;
    we1_nxt   = 1'b0;

    accept      = PxValid & PxReady;
    // An SOF mid-frame restarts the current buffer at word 0.
    sof_restart = accept & PxSOF & (ptr != '0);
    last_word   = accept & ~sof_restart & (ptr == LAST_PTR);
    wr_addr     = sof_restart ? '0 : ptr;

    // A drain pulse frees the buffer this edge; a same-edge set overrides it.
    full0_eff = Buf0Full & ~Buf0Empty;
    full1_eff = Buf1Full & ~Buf1Empty;
    full0_nxt = full0_eff | (last_word & in_fill0);
    full1_nxt = full1_eff | (last_word & in_fill1);

    if (accept) begin
      wdata_nxt = {8'h00, PxR, PxG, PxB};
      we0_nxt   = in_fill0;
      we1_nxt   = in_fill1;
      if (in_fill0) addr0_nxt = wr_addr;
      if (in_fill1) addr1_nxt = wr_addr;
      if (sof_restart)    ptr_nxt = ADDR_W'(1);
      else if (last_word) ptr_nxt = '0;
      else                ptr_nxt = ptr + ADDR_W'(1);
    end

    case (state)
      S_IDLE:  if (Enable) state_nxt = S_FILL0;
      S_FILL0: if (last_word) state_nxt = full1_eff ? S_WAIT1 : S_FILL1;
      S_FILL1: if (last_word) state_nxt = full0_eff ? S_WAIT0 : S_FILL0;
      S_WAIT0: if (Buf0Empty) state_nxt = S_FILL0;
      S_WAIT1: if (Buf1Empty) state_nxt = S_FILL1;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      WData    <= '0;
      WE0      <= 1'b0;
      WE1      <= 1'b0;
      Addr0    <= '0;
      Addr1    <= '0;
      Buf0Full <= 1'b0;
      Buf1Full <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      WData    <= wdata_nxt;
      WE0      <= we0_nxt;
      WE1      <= we1_nxt;
      Addr0    <= addr0_nxt;
      Addr1    <= addr1_nxt;
      Buf0Full <= full0_nxt;
      Buf1Full <= full1_nxt;
    end
  end

`ifdef FRAME_BUFFER_WRITER_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FramesWritten <= '0;
      SOFDrops      <= '0;
    end else begin
      if (last_word && (FramesWritten != 16'hFFFF))
        FramesWritten <= FramesWritten + 16'd1;
      if (sof_restart && (SOFDrops != 8'hFF))
        SOFDrops <= SOFDrops + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_writer
//   Scoreboard bench for frame_buffer_writer with BUF_DEPTH=4. Each accepted
//   pixel pushes the expected buffer/address/word; the write monitor pops and
//   compares on every WE0/WE1 strobe.
// ---------------------------------------------------------------------------
module tb_frame_buffer_writer;

  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned BUF_DEPTH = 4;

  typedef struct packed {
    logic              bsel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              Enable;
  logic [7:0]        PxR, PxG, PxB;
  logic              PxSOF, PxValid, PxReady;
  logic              Buf0Empty, Buf1Empty;
  logic [31:0]       WData;
  logic              WE0, WE1;
  logic [ADDR_W-1:0] Addr0, Addr1;
  logic              Buf0Full, Buf1Full;
`ifdef FRAME_BUFFER_WRITER_STATS_EN
  logic [15:0]       FramesWritten;
  logic [7:0]        SOFDrops;
`endif

  int total = 0;
  int bad   = 0;

  wr_exp_t     sb_q[$];
  logic        m_buf;
  int unsigned m_ptr;
  logic [1:0]  m_full;
  logic [31:0] last_data;

  frame_buffer_writer #(.ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset(reset), .Enable(Enable),
    .PxR(PxR), .PxG(PxG), .PxB(PxB), .PxSOF(PxSOF), .PxValid(PxValid),
    .PxReady(PxReady), .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty),
    .WData(WData), .WE0(WE0), .WE1(WE1), .Addr0(Addr0), .Addr1(Addr1),
    .Buf0Full(Buf0Full), .Buf1Full(Buf1Full)
`ifdef FRAME_BUFFER_WRITER_STATS_EN
    , .FramesWritten(FramesWritten), .SOFDrops(SOFDrops)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding accept.
  always @(negedge clk) begin
    if (WE0 || WE1) begin
      wr_exp_t e;
      check("we_exclusive", 64'(WE0 & WE1), 64'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("wr_buf", 64'(WE1), 64'(e.bsel));
        check("wr_addr", 64'(WE1 ? Addr1 : Addr0), 64'(e.addr));
        check("wr_data", 64'(WData), 64'(e.data));
      end
    end
  end

  task automatic model_reset();
    m_buf  = 1'b0;
    m_ptr  = 0;
    m_full = 2'b00;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_px(input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic sof);
    wr_exp_t e;
    int n = 0;
    PxR = r; PxG = g; PxB = b; PxSOF = sof; PxValid = 1'b1;
    while (!PxReady && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!PxReady) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      e.bsel = m_buf;
      e.data = {8'h00, r, g, b};
      last_data = e.data;
      if (sof && m_ptr != 0) begin
        e.addr = '0;
        m_ptr  = 1;
      end else begin
        e.addr = ADDR_W'(m_ptr);
        if (m_ptr == BUF_DEPTH - 1) begin
          m_full[m_buf] = 1'b1;
          m_buf = ~m_buf;
          m_ptr = 0;
        end else begin
          m_ptr++;
        end
      end
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    PxValid = 1'b0;
    PxSOF   = 1'b0;
  endtask

  task automatic reset_and_enable();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    Enable = 1'b1;
    @(posedge clk); #1;
    Enable = 1'b0;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; Enable = 1'b0; PxR = '0; PxG = '0; PxB = '0;
    PxSOF = 1'b0; PxValid = 1'b0; Buf0Empty = 1'b0; Buf1Empty = 1'b0;
    last_data = '0;
    model_reset();

    // Reset values.
    #12;
    check("rst_ready", 64'(PxReady), 64'd0);
    check("rst_we", 64'({WE0, WE1}), 64'd0);
    check("rst_wdata", 64'(WData), 64'd0);
    check("rst_addr0", 64'(Addr0), 64'd0);
    check("rst_addr1", 64'(Addr1), 64'd0);
    check("rst_full", 64'({Buf0Full, Buf1Full}), 64'd0);

    // Enable -> FILL0.
    @(posedge clk); #1 reset = 1'b1;
    Enable = 1'b1;
    @(posedge clk); #1;
    Enable = 1'b0;
    check("en_ready", 64'(PxReady), 64'd1);
    check("en_we", 64'({WE0, WE1}), 64'd0);
    check("en_full", 64'({Buf0Full, Buf1Full}), 64'd0);

    // Stream one frame into buffer 0; SOF on word 0 is a no-op.
    for (int i = 0; i < 4; i++)
      send_px(8'(i + 1), 8'(i + 2), 8'(i + 3), (i == 0));
    check("fill0_full0", 64'(Buf0Full), 64'd1);
    check("fill0_full1", 64'(Buf1Full), 64'd0);
    check("fill0_ready", 64'(PxReady), 64'd1);
    repeat (2) @(posedge clk); #1;
    check("hold_wdata", 64'(WData), 64'(last_data));
    check("hold_addr0", 64'(Addr0), 64'd3);

    // Fill buffer 1 -> both full, stall in WAIT0.
    for (int i = 0; i < 4; i++)
      send_px(8'(8'h10 + i), 8'h20, 8'h30, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", 64'(PxReady), 64'd0);
      @(posedge clk); #1;
    end
    check("stall_full", 64'({Buf0Full, Buf1Full}), 64'b11);

    // Drain buffer 0.
    Buf0Empty = 1'b1;
    @(posedge clk); #1;
    Buf0Empty = 1'b0;
    m_full[0] = 1'b0;
    check("drain_full0", 64'(Buf0Full), 64'd0);
    check("drain_full1", 64'(Buf1Full), 64'd1);
    check("drain_ready", 64'(PxReady), 64'd1);
    for (int i = 0; i < 3; i++)
      send_px(8'h40, 8'(i), 8'h41, 1'b0);

    // Last word of buffer 0 coincides with buffer 1 drain.
    Buf1Empty = 1'b1;
    m_full[1] = 1'b0;
    send_px(8'h50, 8'h51, 8'h52, 1'b0);
    Buf1Empty = 1'b0;
    check("simul_full0", 64'(Buf0Full), 64'd1);
    check("simul_full1", 64'(Buf1Full), 64'd0);
    check("simul_ready", 64'(PxReady), 64'd1);
    send_px(8'h60, 8'h61, 8'h62, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("hold_addr1", 64'(Addr1), 64'd0);
    check("hold_we", 64'({WE0, WE1}), 64'd0);
`ifdef FRAME_BUFFER_WRITER_STATS_EN
    check("stat_frames", 64'(FramesWritten), 64'd3);
`endif

    // Async reset mid-fill.
    reset_and_enable();
    for (int i = 0; i < 3; i++)
      send_px(8'h70, 8'h71, 8'(i), 1'b0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("arst_we0", 64'(WE0), 64'd0);
    check("arst_full0", 64'(Buf0Full), 64'd0);
    check("arst_ready", 64'(PxReady), 64'd0);
    check("arst_addr0", 64'(Addr0), 64'd0);
    check("arst_queue", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;

    // SOF restart after two words of buffer 0.
    reset_and_enable();
    send_px(8'h01, 8'h01, 8'h01, 1'b0);
    send_px(8'h02, 8'h02, 8'h02, 1'b0);
    send_px(8'h09, 8'h09, 8'h09, 1'b1);
    check("sof_wdata", 64'(WData), 64'h00090909);
    check("sof_addr0", 64'(Addr0), 64'd0);
    check("sof_full0", 64'(Buf0Full), 64'd0);
    send_px(8'h0A, 8'h0A, 8'h0A, 1'b0);
`ifdef FRAME_BUFFER_WRITER_STATS_EN
    check("stat_sofdrops", 64'(SOFDrops), 64'd1);
    check("stat_frames_rst", 64'(FramesWritten), 64'd0);
`endif

    repeat (3) @(posedge clk); #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
